// File: rtl/channel_dump_if.sv
// channel_dump_if: bundles the dump request, capture RAM read port and
// UART byte handshake seen by channel_dump.
// The dump block itself connects through the slave modport.
// The capture controller, RAM and UART side connects through the master modport.
interface channel_dump_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          dump;
  logic [1:0]    dump_chan;
  logic [AW-1:0] start_addr;
  logic [DW-1:0] rdata_ch1;
  logic [DW-1:0] rdata_ch2;
  logic [DW-1:0] rdata_ch3;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] tx_data;
  logic          trmt;
  logic          tx_done;
  logic          busy;
  logic          dump_fin;
  logic          dump_err;

  modport master (
    output dump, dump_chan, start_addr, rdata_ch1, rdata_ch2, rdata_ch3, tx_done,
    input  rd_addr, rd_en, tx_data, trmt, busy, dump_fin, dump_err
  );

  modport slave (
    input  dump, dump_chan, start_addr, rdata_ch1, rdata_ch2, rdata_ch3, tx_done,
    output rd_addr, rd_en, tx_data, trmt, busy, dump_fin, dump_err
  );
endinterface

// File: rtl/channel_dump.sv
// channel_dump: after a capture completes, this block streams one channel's
// circular capture RAM to the UART, oldest sample first.
// Each byte goes out with a trmt/tx_done handshake, and dump_fin pulses once
// the whole trace has been sent.
// Optional feature macro DUMP_HDR_EN: when it is defined, two header bytes
// (8'hA5, then the channel number) are sent before the samples.
module channel_dump #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  channel_dump_if.slave  bus
);

  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
`ifdef DUMP_HDR_EN
    HDR,
`endif
    RD,
    LATCH,
    TX,
    WAIT,
    FIN
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    chan_q, chan_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          rd_en_q, rd_en_d;
  logic          trmt_q, trmt_d;
  logic          busy_q, busy_d;
  logic          dump_fin_q, dump_fin_d;
  logic          dump_err_q, dump_err_d;
  logic [DW-1:0] rdata_sel;
`ifdef DUMP_HDR_EN
  logic          hdr_idx_q, hdr_idx_d;
`endif

  // Pick the read data of the channel latched at dump accept
  always_comb begin
    rdata_sel = bus.rdata_ch1;
    case (chan_q)
      2'b01:   rdata_sel = bus.rdata_ch2;
      2'b10:   rdata_sel = bus.rdata_ch3;
      default: rdata_sel = bus.rdata_ch1;
    endcase
  end

  // Next-state and next-output logic. The strobes rd_en, trmt, dump_fin and
  // dump_err are computed one cycle early so that they come straight from flops.
  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    rd_addr_d  = rd_addr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    rd_en_d    = 1'b0;
    trmt_d     = 1'b0;
    dump_fin_d = 1'b0;
    dump_err_d = 1'b0;
`ifdef DUMP_HDR_EN
    hdr_idx_d  = hdr_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.dump) begin
          if (bus.dump_chan == 2'b11) begin
            dump_err_d = 1'b1;
          end else begin
            chan_d    = bus.dump_chan;
            rd_addr_d = bus.start_addr;
            cnt_d     = '0;
`ifdef DUMP_HDR_EN
            state_d   = HDR;
            tx_data_d = DW'(8'hA5);
            trmt_d    = 1'b1;
            hdr_idx_d = 1'b0;
`else
            state_d   = RD;
            rd_en_d   = 1'b1;
`endif
          end
        end
      end
`ifdef DUMP_HDR_EN
      HDR: begin
        if (bus.tx_done && !trmt_q) begin
          if (!hdr_idx_q) begin
            tx_data_d = DW'(chan_q);
            trmt_d    = 1'b1;
            hdr_idx_d = 1'b1;
          end else begin
            state_d = RD;
            rd_en_d = 1'b1;
          end
        end
      end
`endif
      RD: begin
        state_d = LATCH;
      end
      LATCH: begin
        tx_data_d = rdata_sel;
        trmt_d    = 1'b1;
        state_d   = TX;
      end
      TX: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          if (cnt_q == CW'(DEPTH - 1)) begin
            state_d    = FIN;
            dump_fin_d = 1'b1;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            rd_en_d   = 1'b1;
            state_d   = RD;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any dump in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      chan_q     <= 2'b00;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      rd_en_q    <= 1'b0;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      dump_fin_q <= 1'b0;
      dump_err_q <= 1'b0;
`ifdef DUMP_HDR_EN
      hdr_idx_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      rd_addr_q  <= rd_addr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      rd_en_q    <= rd_en_d;
      trmt_q     <= trmt_d;
      busy_q     <= busy_d;
      dump_fin_q <= dump_fin_d;
      dump_err_q <= dump_err_d;
`ifdef DUMP_HDR_EN
      hdr_idx_q  <= hdr_idx_d;
`endif
    end
  end

  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.trmt     = trmt_q;
  assign bus.busy     = busy_q;
  assign bus.dump_fin = dump_fin_q;
  assign bus.dump_err = dump_err_q;

endmodule

// File: tb/tb_channel_dump.sv
// tb_channel_dump: drives channel_dump with dump requests, models the three
// capture RAMs and a UART with random byte times, and compares every byte
// sent against the trace expected from the RAM contents and start address.
module tb_channel_dump;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:3][0:DEPTH-1];

  channel_dump_if #(.AW(AW), .DW(DW)) bus ();

  channel_dump #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Capture RAM model: registered read, so data is valid one cycle after rd_en
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rdata_ch1 <= mem[0][bus.rd_addr];
      bus.rdata_ch2 <= mem[1][bus.rd_addr];
      bus.rdata_ch3 <= mem[2][bus.rd_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic d, input logic [1:0] ch, input logic [8:0] sa);
    bus.dump       = d;
    bus.dump_chan  = ch;
    bus.start_addr = sa;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},     32'(bus.busy),     0);
    checkOutput({tag, "_rd_en"},    32'(bus.rd_en),    0);
    checkOutput({tag, "_trmt"},     32'(bus.trmt),     0);
    checkOutput({tag, "_dump_fin"}, 32'(bus.dump_fin), 0);
    checkOutput({tag, "_dump_err"}, 32'(bus.dump_err), 0);
    checkOutput({tag, "_rd_addr"},  32'(bus.rd_addr),  0);
    checkOutput({tag, "_tx_data"},  32'(bus.tx_data),  0);
  endtask

  // One complete dump. fixedGap>0 gives a constant tx_done delay, otherwise random.
  // extraAt / spurAt / resetAt are byte indices (or -1) for a second dump request,
  // a tx_done in the trmt cycle, and a reset in WAIT.
  task automatic runDump(input logic [1:0] ch, input logic [8:0] sa, input int fixedGap,
                         input int extraAt, input int spurAt, input int resetAt);
    logic [7:0] expq[$];
    int k, trmtCnt, rdCnt, finCnt, errCnt, doneAt, postFin, postBusy;
    bit finished;
    expq = {};
`ifdef DUMP_HDR_EN
    expq.push_back(8'hA5);
    expq.push_back({6'b0, ch});
`endif
    for (int i = 0; i < DEPTH; i++) expq.push_back(mem[ch][(int'(sa) + i) % DEPTH]);

    @(negedge clk);
    applyStimulus(1'b1, ch, sa);
    k = 0; trmtCnt = 0; rdCnt = 0; finCnt = 0; errCnt = 0; doneAt = -1; finished = 0;
    while (!finished && k < 20000) begin
      @(negedge clk);
      k++;
      bus.dump    = 1'b0;
      bus.tx_done = 1'b0;
      if (k == 1) begin
        checkOutput("busy_after_accept", 32'(bus.busy), 1);
`ifdef DUMP_HDR_EN
        checkOutput("hdr_first_trmt", 32'(bus.trmt), 1);
        checkOutput("hdr_no_rd_en", 32'(bus.rd_en), 0);
`else
        checkOutput("latency_rd_en", 32'(bus.rd_en), 1);
`endif
      end
`ifndef DUMP_HDR_EN
      if (k == 3) checkOutput("latency_trmt", 32'(bus.trmt), 1);
`endif
      if (bus.dump_err) errCnt++;
      if (bus.rd_en) begin
        checkOutput("rd_addr", 32'(bus.rd_addr), (int'(sa) + rdCnt) % DEPTH);
        rdCnt++;
      end
      if (bus.dump_fin) begin
        finCnt++;
        checkOutput("fin_after_all_bytes", trmtCnt, expq.size());
        @(negedge clk);
        checkOutput("busy_low_after_fin", 32'(bus.busy), 0);
        checkOutput("no_trmt_after_fin", 32'(bus.trmt), 0);
        finished = 1;
      end else if (bus.trmt) begin
        if (trmtCnt < expq.size()) checkOutput("tx_byte", 32'(bus.tx_data), 32'(expq[trmtCnt]));
        else checkOutput("trmt_overrun", trmtCnt, expq.size());
        trmtCnt++;
        doneAt = k + ((fixedGap > 0) ? fixedGap : int'($urandom_range(1, 6)));
        if (trmtCnt - 1 == spurAt) bus.tx_done = 1'b1;
        if (trmtCnt - 1 == extraAt) applyStimulus(1'b1, 2'b00, 9'd0);
      end else if (k == doneAt) begin
        if (resetAt >= 0 && trmtCnt - 1 == resetAt) begin
          rst_n = 1'b0;
          #1;
          checkAllZero("async_reset");
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          postFin = 0; postBusy = 0;
          repeat (20) begin
            @(negedge clk);
            if (bus.dump_fin) postFin++;
            if (bus.busy) postBusy++;
          end
          checkOutput("no_fin_after_reset", postFin, 0);
          checkOutput("idle_after_reset", postBusy, 0);
          finished = 1;
        end else begin
          bus.tx_done = 1'b1;
        end
      end
    end
    bus.dump    = 1'b0;
    bus.tx_done = 1'b0;
    checkOutput("dump_completed", 32'(finished), 1);
    if (resetAt < 0) begin
      checkOutput("trmt_total", trmtCnt, expq.size());
      checkOutput("rd_total", rdCnt, DEPTH);
      checkOutput("fin_count", finCnt, 1);
    end
    checkOutput("no_dump_err", errCnt, 0);
  endtask

  task automatic runInvalid();
    int seen;
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 9'd5);
    @(negedge clk);
    bus.dump = 1'b0;
    checkOutput("dump_err_pulse", 32'(bus.dump_err), 1);
    checkOutput("busy_on_invalid", 32'(bus.busy), 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_en || bus.trmt || bus.busy || bus.dump_err) seen++;
    end
    checkOutput("invalid_no_activity", seen, 0);
  endtask

  initial begin
    applyStimulus(1'b0, 2'b00, 9'd0);
    bus.tx_done = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      mem[0][a] = 8'(a);
      mem[1][a] = 8'($urandom);
      mem[2][a] = 8'($urandom);
      mem[3][a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    runDump(2'b00, 9'd0, 10, -1, -1, -1);
    runDump(2'b01, 9'd500, 0, -1, -1, -1);
    runInvalid();
    runDump(2'b10, 9'($urandom_range(0, DEPTH - 1)), 0, 100, 50, -1);
    runDump(2'b01, 9'd123, 0, -1, -1, 37);
    runDump(2'b00, 9'd300, 0, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
